// File: rtl/wave_gen.sv
// Multi-mode waveform generator (triangle, ramp-up, ramp-down, square) between runtime bounds.
// Optional completed-period counter output pcnt is built when WAVE_GEN_PCNT_EN is defined.
module wave_gen #(
  parameter int DW     = 9,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              en,
  input  logic              cfg_ld,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [DW-1:0]     lo,
  input  logic [DW-1:0]     hi,
  output logic [DW-1:0]     d_out,
  output logic              wrap,
  output logic              cfg_err
`ifdef WAVE_GEN_PCNT_EN
  ,
  output logic [15:0]       pcnt
`endif
);

  localparam int AW = ((DW > STEP_W) ? DW : STEP_W) + 1;

  localparam logic [1:0] M_TRI = 2'b00;
  localparam logic [1:0] M_RUP = 2'b01;
  localparam logic [1:0] M_RDN = 2'b10;

  typedef enum logic [2:0] {IDLE, UP, DOWN, HOLD_HI, HOLD_LO} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       d_nxt;
  logic                wrap_nxt, err_nxt;
  logic [STEP_W-1:0]   cnt, cnt_nxt;

  logic [1:0]          a_mode, s_mode, eff_mode;
  logic [STEP_W-1:0]   a_step, s_step, eff_step;
  logic [DW-1:0]       a_lo, a_hi, s_lo, s_hi, eff_lo, eff_hi;
  logic                s_vld;
  logic                load, restart, bnd, eff_err;
  logic [STEP_W-1:0]   a_st;

  function automatic logic [STEP_W-1:0] norm_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

  // Saturating add: result clamped to h, computed without wrap-around.
  function automatic logic [DW-1:0] add_clamp(input logic [DW-1:0] d,
                                               input logic [STEP_W-1:0] s,
                                               input logic [DW-1:0] h);
    logic [AW-1:0] sum;
    sum = AW'(d) + AW'(s);
    return (sum >= AW'(h)) ? h : sum[DW-1:0];
  endfunction

  // Saturating subtract: d - s <= l is tested as d <= l + s to stay unsigned.
  function automatic logic [DW-1:0] sub_clamp(input logic [DW-1:0] d,
                                               input logic [STEP_W-1:0] s,
                                               input logic [DW-1:0] l);
    logic [AW-1:0] dif;
    dif = AW'(d) - AW'(s);
    return (AW'(d) <= AW'(l) + AW'(s)) ? l : dif[DW-1:0];
  endfunction

  function automatic state_t start_state(input logic [1:0] m);
    case (m)
      M_TRI, M_RUP: return UP;
      M_RDN:        return DOWN;
      default:      return HOLD_LO;
    endcase
  endfunction

  // A pending shadow config is what gets loaded whenever the active config reloads.
  assign eff_mode = s_vld ? s_mode : a_mode;
  assign eff_step = s_vld ? s_step : a_step;
  assign eff_lo   = s_vld ? s_lo   : a_lo;
  assign eff_hi   = s_vld ? s_hi   : a_hi;
  assign eff_err  = (eff_lo >= eff_hi);
  assign a_st     = norm_step(a_step);

  always_comb begin
    state_nxt = state;
    d_nxt     = d_out;
    wrap_nxt  = 1'b0;
    err_nxt   = cfg_err;
    cnt_nxt   = cnt;
    load      = 1'b0;
    restart   = 1'b0;
    bnd       = 1'b0;

    if (state == IDLE) begin
      load    = 1'b1;
      restart = en;
    end else if (!en) begin
      state_nxt = IDLE;
    end else if (cfg_err) begin
      // Parked on an invalid config: retry every clock until a valid one arrives.
      load    = 1'b1;
      restart = 1'b1;
    end else begin
      case (state)
        UP: begin
          if (a_mode == M_RUP && d_out == a_hi) begin
            bnd = 1'b1;
          end else begin
            d_nxt = add_clamp(d_out, a_st, a_hi);
            if (a_mode == M_TRI && d_nxt == a_hi) state_nxt = DOWN;
          end
        end
        DOWN: begin
          if (a_mode == M_RDN) begin
            if (d_out == a_lo) bnd = 1'b1;
            else d_nxt = sub_clamp(d_out, a_st, a_lo);
          end else if (sub_clamp(d_out, a_st, a_lo) == a_lo) begin
            bnd = 1'b1;
          end else begin
            d_nxt = sub_clamp(d_out, a_st, a_lo);
          end
        end
        HOLD_LO: begin
          if (cnt >= a_st) begin
            state_nxt = HOLD_HI;
            d_nxt     = a_hi;
            cnt_nxt   = STEP_W'(1);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HOLD_HI: begin
          if (cnt >= a_st) bnd = 1'b1;
          else cnt_nxt = cnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (bnd) begin
      load     = 1'b1;
      restart  = 1'b1;
      wrap_nxt = !eff_err;
    end

    if (load) err_nxt = eff_err;

    if (restart) begin
      cnt_nxt = STEP_W'(1);
      if (eff_err) begin
        d_nxt     = eff_lo;
        state_nxt = HOLD_LO;
      end else begin
        d_nxt     = (eff_mode == M_RDN) ? eff_hi : eff_lo;
        state_nxt = start_state(eff_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      d_out   <= '0;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
      cnt     <= '0;
      a_mode  <= M_TRI;
      a_step  <= STEP_W'(1);
      a_lo    <= '0;
      a_hi    <= '1;
      s_vld   <= 1'b0;
    end else begin
      state   <= state_nxt;
      d_out   <= d_nxt;
      wrap    <= wrap_nxt;
      cfg_err <= err_nxt;
      cnt     <= cnt_nxt;
      if (load) begin
        a_mode <= eff_mode;
        a_step <= eff_step;
        a_lo   <= eff_lo;
        a_hi   <= eff_hi;
      end
      if (cfg_ld)    s_vld <= 1'b1;
      else if (load) s_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ld) begin
      s_mode <= mode;
      s_step <= step;
      s_lo   <= lo;
      s_hi   <= hi;
    end
  end

`ifdef WAVE_GEN_PCNT_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res)          pcnt <= '0;
    else if (wrap_nxt) pcnt <= pcnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen; covers pcnt too when WAVE_GEN_PCNT_EN is defined.
module tb_wave_gen;
  logic       clk, res, en, cfg_ld;
  logic [1:0] mode;
  logic [7:0] step;
  logic [8:0] lo, hi, d_out;
  logic       wrap, cfg_err;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         exp_pcnt = 0;
`ifdef WAVE_GEN_PCNT_EN
  logic [15:0] pcnt;
`endif

  wave_gen #(.DW(9), .STEP_W(8)) dut (
    .clk(clk), .res(res), .en(en), .cfg_ld(cfg_ld), .mode(mode), .step(step),
    .lo(lo), .hi(hi), .d_out(d_out), .wrap(wrap), .cfg_err(cfg_err)
`ifdef WAVE_GEN_PCNT_EN
    , .pcnt(pcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int exp_d, input bit exp_w);
    logic [8:0] e;
    e = exp_d[8:0];
    n_assert++;
    assert (d_out === e) else begin
      n_fail++;
      $error("FAIL %s d_out: observed %0d expected %0d", tag, d_out, e);
    end
    n_assert++;
    assert (wrap === exp_w) else begin
      n_fail++;
      $error("FAIL %s wrap: observed %b expected %b", tag, wrap, exp_w);
    end
    if (exp_w) exp_pcnt++;
`ifdef WAVE_GEN_PCNT_EN
    n_assert++;
    assert (pcnt === exp_pcnt[15:0]) else begin
      n_fail++;
      $error("FAIL %s pcnt: observed %0d expected %0d", tag, pcnt, exp_pcnt);
    end
`endif
  endtask

  task automatic step_chk(input string tag, input int exp_d, input bit exp_w);
    tick();
    chk_out(tag, exp_d, exp_w);
  endtask

  task automatic chk_err(input string tag, input bit exp_e);
    n_assert++;
    assert (cfg_err === exp_e) else begin
      n_fail++;
      $error("FAIL %s cfg_err: observed %b expected %b", tag, cfg_err, exp_e);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input int s, input int l, input int h);
    mode   = m;
    step   = s[7:0];
    lo     = l[8:0];
    hi     = h[8:0];
    cfg_ld = 1'b1;
  endtask

  initial begin
    res = 1'b0; en = 1'b0; cfg_ld = 1'b0;
    mode = 2'b00; step = 8'd0; lo = 9'd0; hi = 9'd0;

    // reset asserted, then released with en low
    #10;
    chk_out("rst_during", 0, 0);
    chk_err("rst_during", 0);
    #7 res = 1'b1;
    tick();
    chk_out("rst_after", 0, 0);
    chk_err("rst_after", 0);

    // triangle 0..10 step 3
    set_cfg(2'b00, 3, 0, 10);
    step_chk("tri_idle", 0, 0);
    cfg_ld = 1'b0; en = 1'b1;
    step_chk("tri_start", 0, 0);
    step_chk("tri", 3, 0);  step_chk("tri", 6, 0);  step_chk("tri", 9, 0);
    step_chk("tri_hi", 10, 0);
    step_chk("tri", 7, 0);  step_chk("tri", 4, 0);  step_chk("tri", 1, 0);
    step_chk("tri_wrap", 0, 1);
    step_chk("tri", 3, 0);  step_chk("tri", 6, 0);

    // mid-period reconfig to ramp-up 0..50: takes effect at the boundary
    set_cfg(2'b01, 3, 0, 50);
    step_chk("mid_cfg", 9, 0);
    cfg_ld = 1'b0;
    step_chk("mid_old", 10, 0); step_chk("mid_old", 7, 0);
    step_chk("mid_old", 4, 0);  step_chk("mid_old", 1, 0);
    step_chk("mid_bnd", 0, 1);
    step_chk("mid_new", 3, 0);  step_chk("mid_new", 6, 0); step_chk("mid_new", 9, 0);

    // drop enable: output frozen
    en = 1'b0;
    step_chk("en_off", 9, 0);
    step_chk("en_off", 9, 0);

    // ramp-up 5..20 step 7, loaded while idle
    set_cfg(2'b01, 7, 5, 20);
    step_chk("rup_idle", 9, 0);
    cfg_ld = 1'b0; en = 1'b1;
    step_chk("rup_start", 5, 0);
    step_chk("rup", 12, 0); step_chk("rup", 19, 0);
    step_chk("rup_clamp", 20, 0);
    step_chk("rup_wrap", 5, 1);
    step_chk("rup", 12, 0);

    // ramp-down same bounds
    en = 1'b0;
    set_cfg(2'b10, 7, 5, 20);
    step_chk("rdn_idle", 12, 0);
    cfg_ld = 1'b0; en = 1'b1;
    step_chk("rdn_start", 20, 0);
    step_chk("rdn", 13, 0); step_chk("rdn", 6, 0);
    step_chk("rdn_clamp", 5, 0);
    step_chk("rdn_wrap", 20, 1);
    step_chk("rdn", 13, 0);

    // square 0/299, half-period 4
    en = 1'b0;
    set_cfg(2'b11, 4, 0, 299);
    step_chk("sq_idle", 13, 0);
    cfg_ld = 1'b0; en = 1'b1;
    step_chk("sq_lo", 0, 0);   step_chk("sq_lo", 0, 0);
    step_chk("sq_lo", 0, 0);   step_chk("sq_lo", 0, 0);
    step_chk("sq_hi", 299, 0); step_chk("sq_hi", 299, 0);
    step_chk("sq_hi", 299, 0); step_chk("sq_hi", 299, 0);
    step_chk("sq_wrap", 0, 1);
    step_chk("sq_lo", 0, 0);

    // square with step 0 -> one-clock half-periods
    en = 1'b0;
    set_cfg(2'b11, 0, 0, 299);
    step_chk("sq0_idle", 0, 0);
    cfg_ld = 1'b0; en = 1'b1;
    step_chk("sq0_lo", 0, 0);
    step_chk("sq0_hi", 299, 0);
    step_chk("sq0_wrap", 0, 1);

    // invalid config lo == hi applied at the next boundary
    set_cfg(2'b00, 3, 12, 12);
    step_chk("err_ld", 299, 0);
    cfg_ld = 1'b0;
    step_chk("err_park", 12, 0);
    chk_err("err_park", 1);
    step_chk("err_hold", 12, 0);
    chk_err("err_hold", 1);

    // valid config releases the park without a wrap pulse
    set_cfg(2'b00, 3, 0, 10);
    step_chk("fix_ld", 12, 0);
    cfg_ld = 1'b0;
    step_chk("fix_start", 0, 0);
    chk_err("fix_start", 0);
    step_chk("fix_run", 3, 0);

    // async reset mid-period discards a pending shadow config
    set_cfg(2'b10, 7, 5, 20);
    step_chk("ar_pre", 6, 0);
    cfg_ld = 1'b0;
    #3 res = 1'b0;
    #1;
    exp_pcnt = 0;
    chk_out("ar_async", 0, 0);
    chk_err("ar_async", 0);
    #2 res = 1'b1;
    step_chk("ar_default", 0, 0);
    step_chk("ar_default", 1, 0);
    step_chk("ar_default", 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
